// File: rtl/rv32_mvu_job_dispatcher.sv
// Serialises per-hart MVU start requests onto one shared job port. Harts are served round-robin and
// each job's CSR descriptor is snapshotted at grant time.
module rv32_mvu_job_dispatcher #(
  parameter  int NUM_HARTS = 8,
  localparam int HW        = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_HARTS-1:0]    mvu_start,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_wbaseaddr,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_ibaseaddr,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_obaseaddr,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_precision,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_quant,
  input  logic [32*NUM_HARTS-1:0] csr_mvu_command,
  output logic                    job_valid,
  input  logic                    job_ready,
  output logic [HW-1:0]           job_hart,
  output logic [31:0]             job_wbase,
  output logic [31:0]             job_ibase,
  output logic [31:0]             job_obase,
  output logic [31:0]             job_prec,
  output logic [31:0]             job_quant,
  output logic [31:0]             job_cmd,
  input  logic                    mvu_done,
  output logic [NUM_HARTS-1:0]    mvu_irq,
  output logic [NUM_HARTS-1:0]    pending,
  output logic [NUM_HARTS-1:0]    start_drop
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, IRQ} state_e;

  typedef struct packed {
    logic [31:0] wbase;
    logic [31:0] ibase;
    logic [31:0] obase;
    logic [31:0] prec;
    logic [31:0] quant;
    logic [31:0] cmd;
  } job_desc_t;

  state_e                state_q, state_d;
  logic [NUM_HARTS-1:0]  pending_q, pending_d;
  logic [NUM_HARTS-1:0]  start_drop_q, start_drop_d;
  logic [NUM_HARTS-1:0]  mvu_irq_q, mvu_irq_d;
  logic [HW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]         job_hart_q, job_hart_d;
  logic                  job_valid_q, job_valid_d;
  job_desc_t             desc_q, desc_d;

  logic                  grant;
  logic [HW-1:0]         winner;
  logic [NUM_HARTS-1:0]  grant_mask;

  // Arbiter: first pending hart at or after rr_ptr, wrapping; looks only at registered pending.
  always_comb begin
    int  idx;
    logic found;
    // NOTE: every variable written here gets a default first so no latch is inferred.
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_HARTS;
      if (!found && pending_q[idx]) begin
        found  = 1'b1;
        winner = HW'(idx);
      end
    end
  end

  assign grant = (state_q == IDLE) && (|pending_q);

  always_comb begin
    grant_mask = '0;
    if (grant) grant_mask[winner] = 1'b1;
  end

  // A start coinciding with the grant of the same hart is a fresh request, not a drop.
  always_comb begin
    pending_d    = (pending_q & ~grant_mask) | mvu_start;
    start_drop_d = start_drop_q | (mvu_start & pending_q & ~grant_mask);
    rr_ptr_d     = rr_ptr_q;
    if (grant) rr_ptr_d = (winner == HW'(NUM_HARTS - 1)) ? '0 : winner + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = ISSUE;
      ISSUE:   if (job_ready)  state_d = RUN;
      RUN:     if (mvu_done)   state_d = IRQ;
      IRQ:                     state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM: registered outputs; mvu_done outside RUN is deliberately ignored.
  always_comb begin
    int base;
    base        = 32 * int'(winner);
    job_valid_d = job_valid_q;
    job_hart_d  = job_hart_q;
    desc_d      = desc_q;
    mvu_irq_d   = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          job_valid_d  = 1'b1;
          job_hart_d   = winner;
          desc_d.wbase = csr_mvu_wbaseaddr[base +: 32];
          desc_d.ibase = csr_mvu_ibaseaddr[base +: 32];
          desc_d.obase = csr_mvu_obaseaddr[base +: 32];
          desc_d.prec  = csr_mvu_precision[base +: 32];
          desc_d.quant = csr_mvu_quant[base +: 32];
          desc_d.cmd   = csr_mvu_command[base +: 32];
        end
      end
      ISSUE:   if (job_ready) job_valid_d = 1'b0;
      RUN:     if (mvu_done)  mvu_irq_d[job_hart_q] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      start_drop_q <= '0;
      mvu_irq_q    <= '0;
      rr_ptr_q     <= '0;
      job_hart_q   <= '0;
      job_valid_q  <= 1'b0;
      desc_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      start_drop_q <= start_drop_d;
      mvu_irq_q    <= mvu_irq_d;
      rr_ptr_q     <= rr_ptr_d;
      job_hart_q   <= job_hart_d;
      job_valid_q  <= job_valid_d;
      desc_q       <= desc_d;
    end
  end

  assign job_valid  = job_valid_q;
  assign job_hart   = job_hart_q;
  assign job_wbase  = desc_q.wbase;
  assign job_ibase  = desc_q.ibase;
  assign job_obase  = desc_q.obase;
  assign job_prec   = desc_q.prec;
  assign job_quant  = desc_q.quant;
  assign job_cmd    = desc_q.cmd;
  assign mvu_irq    = mvu_irq_q;
  assign pending    = pending_q;
  assign start_drop = start_drop_q;

endmodule

// File: tb/tb_rv32_mvu_job_dispatcher.sv
// Bench for rv32_mvu_job_dispatcher: expected grants are queued as starts are driven and
// compared when the job port accepts; completions are matched against accepted jobs.
module tb_rv32_mvu_job_dispatcher;

  localparam int NH = 8;

  typedef struct packed {
    logic [2:0]   hart;
    logic [191:0] desc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NH-1:0]   mvu_start = '0;
  logic [32*NH-1:0] csr_w, csr_i, csr_o, csr_p, csr_q, csr_c;
  logic            job_valid, job_ready = 1'b0;
  logic [2:0]      job_hart;
  logic [31:0]     job_wbase, job_ibase, job_obase, job_prec, job_quant, job_cmd;
  logic            mvu_done = 1'b0;
  logic [NH-1:0]   mvu_irq, pending, start_drop;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   irq_cnt  = 0;
  exp_t exp_q[$];
  int   irq_q[$];
  exp_t mon_e;
  int   mon_h;
  logic [NH-1:0] mon_mask;

  always #5 clk = ~clk;

  rv32_mvu_job_dispatcher #(.NUM_HARTS(NH)) dut (
    .clk(clk), .rst_n(rst_n), .mvu_start(mvu_start),
    .csr_mvu_wbaseaddr(csr_w), .csr_mvu_ibaseaddr(csr_i), .csr_mvu_obaseaddr(csr_o),
    .csr_mvu_precision(csr_p), .csr_mvu_quant(csr_q), .csr_mvu_command(csr_c),
    .job_valid(job_valid), .job_ready(job_ready), .job_hart(job_hart),
    .job_wbase(job_wbase), .job_ibase(job_ibase), .job_obase(job_obase),
    .job_prec(job_prec), .job_quant(job_quant), .job_cmd(job_cmd),
    .mvu_done(mvu_done), .mvu_irq(mvu_irq), .pending(pending), .start_drop(start_drop)
  );

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [191:0] desc(input int h);
    return {32'h1000_0000 + 32'(h) * 32'h100, 32'h2000_0000 + 32'(h), 32'h3000_0000 + 32'(h),
            32'(h * 3 + 1), 32'h55 + 32'(h), 32'hC0DE_0000 | 32'(h)};
  endfunction

  function automatic logic [191:0] job_bus();
    return {job_wbase, job_ibase, job_obase, job_prec, job_quant, job_cmd};
  endfunction

  task automatic expect_job(input int h);
    exp_t e;
    e.hart = 3'(h);
    e.desc = desc(h);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!job_valid && k < 100) begin
      tick();
      k++;
    end
    check("valid_timeout", job_valid, 1);
  endtask

  // Serves n jobs with job_ready already high; done follows each accept by three cycles.
  task automatic run_jobs(input int n);
    for (int j = 0; j < n; j++) begin
      wait_valid();
      repeat (3) tick();
      mvu_done = 1'b1;
      tick();
      mvu_done = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid", job_valid, 0);
    check("rst_irq", mvu_irq, 0);
    check("rst_pending", pending, 0);
    check("rst_drop", start_drop, 0);
    check("rst_hart", job_hart, 0);
    check("rst_desc", job_bus(), 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    irq_q.delete();
  endtask

  // Monitor: accepted descriptors against the expected queue, completions against accepted jobs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (job_valid && job_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept", job_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_hart", job_hart, mon_e.hart);
          check("grant_desc", job_bus(), mon_e.desc);
          irq_q.push_back(int'(mon_e.hart));
        end
      end
      if (mvu_irq != '0) begin
        if (irq_q.size() == 0) begin
          check("unexpected_irq", mvu_irq, 0);
        end else begin
          mon_h    = irq_q.pop_front();
          mon_mask = NH'(1) << mon_h;
          check("irq_vector", mvu_irq, mon_mask);
          irq_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] d;
    int irq_base;
    for (int h = 0; h < NH; h++) begin
      d = desc(h);
      csr_w[h*32 +: 32] = d[191:160];
      csr_i[h*32 +: 32] = d[159:128];
      csr_o[h*32 +: 32] = d[127:96];
      csr_p[h*32 +: 32] = d[95:64];
      csr_q[h*32 +: 32] = d[63:32];
      csr_c[h*32 +: 32] = d[31:0];
    end
    @(posedge clk);
    #1;
    do_reset();

    // Single job on hart 3 with exact cycle timing
    mvu_start = 8'h08;
    expect_job(3);
    tick();
    mvu_start = '0;
    check("t1_pending_c1", pending, 8'h08);
    check("t1_valid_c1", job_valid, 0);
    tick();
    check("t1_valid_c2", job_valid, 1);
    check("t1_hart", job_hart, 3);
    check("t1_wbase", job_wbase, 32'h1000_0300);
    check("t1_pending_c2", pending, 0);
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    check("t1_valid_c3", job_valid, 0);
    repeat (7) tick();
    mvu_done = 1'b1;
    tick();
    mvu_done = 1'b0;
    check("t1_irq_c11", mvu_irq, 8'h08);
    tick();
    check("t1_irq_c12", mvu_irq, 0);

    // Round robin from a fresh pointer
    do_reset();
    irq_base  = irq_cnt;
    job_ready = 1'b1;
    mvu_start = 8'hFF;
    for (int h = 0; h < NH; h++) expect_job(h);
    tick();
    mvu_start = '0;
    run_jobs(8);
    check("rr_pending", pending, 0);
    check("rr_irq_count", irq_cnt - irq_base, 8);

    // Wrap: grant 5, then 0 and 6 pending -> 6 then 0; pointer then at 1
    mvu_start = 8'h20;
    expect_job(5);
    tick();
    mvu_start = '0;
    run_jobs(1);
    mvu_start = 8'h41;
    expect_job(6);
    expect_job(0);
    tick();
    mvu_start = '0;
    run_jobs(2);
    mvu_start = 8'h03;
    expect_job(1);
    expect_job(0);
    tick();
    mvu_start = '0;
    run_jobs(2);

    // Backpressure, CSR change after grant, and a stray done while issuing
    job_ready = 1'b0;
    mvu_start = 8'h10;
    expect_job(4);
    tick();
    mvu_start = '0;
    wait_valid();
    csr_w[4*32 +: 32] = 32'hDEAD_0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) mvu_done = 1'b1;
      if (i == 6) mvu_done = 1'b0;
      if (i % 5 == 4) begin
        check("bp_valid", job_valid, 1);
        check("bp_wbase", job_wbase, 32'h1000_0400);
      end
    end
    d = desc(4);
    csr_w[4*32 +: 32] = d[191:160];
    job_ready = 1'b1;
    run_jobs(1);

    // Drop: hart 2 restarted twice while already pending behind hart 7
    job_ready = 1'b0;
    mvu_start = 8'h80;
    expect_job(7);
    tick();
    mvu_start = '0;
    wait_valid();
    mvu_start = 8'h04;
    expect_job(2);
    repeat (3) tick();
    mvu_start = '0;
    tick();
    check("drop_flag", start_drop, 8'h04);
    check("drop_pending", pending, 8'h04);
    job_ready = 1'b1;
    run_jobs(2);
    repeat (10) tick();
    check("drop_single_job", job_valid, 0);
    check("drop_pending_end", pending, 0);

    // Start on the grant cycle of the same hart is a new request
    do_reset();
    job_ready = 1'b0;
    mvu_start = 8'h04;
    expect_job(2);
    tick();
    expect_job(2);
    tick();
    mvu_start = '0;
    check("sim_valid", job_valid, 1);
    check("sim_pending", pending, 8'h04);
    check("sim_drop", start_drop, 0);
    job_ready = 1'b1;
    run_jobs(2);
    check("sim_drop_end", start_drop, 0);
    check("sim_pending_end", pending, 0);

    // Reset while the job is running, then a late done
    mvu_start = 8'h02;
    expect_job(1);
    tick();
    mvu_start = '0;
    wait_valid();
    repeat (3) tick();
    check("mid_hart_before", job_hart, 1);
    do_reset();
    mvu_done = 1'b1;
    tick();
    mvu_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_irq", mvu_irq, 0);
    end
    check("mid_valid", job_valid, 0);

    check("exp_queue_drained", exp_q.size(), 0);
    check("irq_queue_drained", irq_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
